// File: rtl/vga_fb_writer.sv
// Write side of a 1bpp framebuffer: pixel clear/set/toggle by read-modify-write of a
// 32-bit SRAM word, and whole-screen fill, all through one shared SRAM request port.
module vga_fb_writer #(
    parameter int FB_W      = 128,
    parameter int FB_H      = 96,
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0,
    localparam int XW       = $clog2(FB_W),
    localparam int YW       = $clog2(FB_H)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [XW-1:0]     cmd_x_i,
    input  logic [YW-1:0]     cmd_y_i,
    input  logic              cmd_fill_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_busy_i,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        dbg_state_o
);
    localparam int WORDS = FB_W * FB_H / 32;
    localparam int CW    = $clog2(WORDS);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_REQ    = 3'd1;
    localparam logic [2:0] RD_WAIT   = 3'd2;
    localparam logic [2:0] WR_REQ    = 3'd3;
    localparam logic [2:0] WR_WAIT   = 3'd4;
    localparam logic [2:0] FILL_REQ  = 3'd5;
    localparam logic [2:0] FILL_WAIT = 3'd6;
    localparam logic [2:0] DROP      = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [4:0]        bit_q, bit_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] pix_addr;
    logic              in_range;
    logic [31:0]       mask;

    assign pix_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(cmd_y_i) * ADDR_W'(FB_W / 32)
                    + ADDR_W'(cmd_x_i >> 5);
    assign in_range = (32'(cmd_x_i) < FB_W) && (32'(cmd_y_i) < FB_H);
    assign mask     = 32'd1 << bit_q;

    // A request stays up (with addr/wdata frozen in their registers) until busy is low.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_op_i == 2'b11) begin
                        cnt_d   = '0;
                        addr_d  = ADDR_W'(BASE_ADDR);
                        wdata_d = {32{cmd_fill_i}};
                        state_d = FILL_REQ;
                    end else if (in_range) begin
                        addr_d  = pix_addr;
                        bit_d   = cmd_x_i[4:0];
                        op_d    = cmd_op_i;
                        state_d = RD_REQ;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            RD_REQ:  if (!mem_busy_i) state_d = RD_WAIT;
            RD_WAIT: begin
                if (!mem_busy_i) begin
                    case (op_q)
                        2'b00:   wdata_d = mem_rdata_i & ~mask;
                        2'b01:   wdata_d = mem_rdata_i | mask;
                        2'b10:   wdata_d = mem_rdata_i ^ mask;
                        default: wdata_d = mem_rdata_i;
                    endcase
                    state_d = WR_REQ;
                end
            end
            WR_REQ:  if (!mem_busy_i) state_d = WR_WAIT;
            WR_WAIT: begin
                if (!mem_busy_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            FILL_REQ: if (!mem_busy_i) state_d = FILL_WAIT;
            FILL_WAIT: begin
                if (!mem_busy_i) begin
                    if (cnt_q == CW'(WORDS - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = FILL_REQ;
                    end
                end
            end
            default: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            bit_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign mem_rd_en_o = (state_q == RD_REQ);
    assign mem_wr_en_o = (state_q == WR_REQ) || (state_q == FILL_REQ);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;
endmodule
